// File: rtl/audio_seq_pkg.sv
// Shared types for the audio note sequencer: FSM states, step-table entry layout.
package audio_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StPlay,
      StGap
   } seq_state_t;

   typedef struct packed {
      logic [15:0] freq;
      logic [15:0] dur;
   } step_entry_t;

   // Field positions inside a cfg_data_i word
   localparam int unsigned FreqMsb = 31;
   localparam int unsigned FreqLsb = 16;
   localparam int unsigned DurMsb  = 15;
   localparam int unsigned DurLsb  = 0;

endpackage

// File: rtl/audio_tick_prescaler.sv
// Divides clk_i down to a one-cycle duration tick every TICK_DIV enabled cycles.
module audio_tick_prescaler #(
   parameter int unsigned TICK_DIV = 48000
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CntLast = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise wrap at TICK_DIV-1 while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/audio_note_sequencer.sv
// Step sequencer: plays a programmable table of {freq, duration} steps with gate and gap.
module audio_note_sequencer
   import audio_seq_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned TICK_DIV  = 48000,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       cfg_we_i,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
   input  logic [31:0]                cfg_data_i,
   input  logic [$clog2(DEPTH):0]     len_i,
   input  logic                       loop_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   output logic [15:0]                freq_o,
   output logic                       gate_o,
   output logic [$clog2(DEPTH)-1:0]   step_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned GW = (GAP_TICKS == 0) ? 1 : $clog2(GAP_TICKS + 1);

   seq_state_t     state_q, state_d;
   logic [15:0]    freq_q, freq_d;
   logic [AW-1:0]  step_q, step_d;
   logic [LW-1:0]  len_q, len_d;
   logic           loop_q, loop_d;
   logic [15:0]    dur_q, dur_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           done_q, done_d;
   logic           busy_q;
   logic           tick;
   logic           advance;
   step_entry_t    table_q [DEPTH];
   step_entry_t    entry;

   // Step table: no reset, contents undefined until written
   always_ff @(posedge clk_i) begin
      if (cfg_we_i) begin
         table_q[cfg_addr_i] <= '{freq: cfg_data_i[FreqMsb:FreqLsb],
                                  dur:  cfg_data_i[DurMsb:DurLsb]};
      end
   end

   assign entry = table_q[step_q];

   audio_tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  ((state_q == StIdle) || (state_q == StLoad) || stop_i),
      .en_i   ((state_q == StPlay) || (state_q == StGap)),
      .tick_o (tick)
   );

   // Next-state logic; stop_i overrides everything computed above it
   always_comb begin
      state_d = state_q;
      freq_d  = freq_q;
      step_d  = step_q;
      len_d   = len_q;
      loop_d  = loop_q;
      dur_d   = dur_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      advance = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i && (len_i != '0)) begin
               state_d = StLoad;
               len_d   = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
               loop_d  = loop_i;
               step_d  = '0;
            end
         end
         StLoad: begin
            freq_d  = entry.freq;
            dur_d   = (entry.dur == 16'd0) ? 16'd1 : entry.dur;
            state_d = StPlay;
         end
         StPlay: begin
            if (tick) begin
               if (dur_q == 16'd1) begin
                  if (GAP_TICKS > 0) begin
                     state_d = StGap;
                     gap_d   = GW'(GAP_TICKS);
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  dur_d = dur_q - 16'd1;
               end
            end
         end
         StGap: begin
            if (tick) begin
               if (gap_q == GW'(1)) begin
                  advance = 1'b1;
               end else begin
                  gap_d = gap_q - GW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if ((LW'(step_q) + LW'(1)) < len_q) begin
            step_d  = step_q + AW'(1);
            state_d = StLoad;
         end else if (loop_q) begin
            step_d  = '0;
            state_d = StLoad;
         end else begin
            state_d = StIdle;
            freq_d  = '0;
            done_d  = 1'b1;
         end
      end

      if (stop_i) begin
         state_d = StIdle;
         freq_d  = '0;
         done_d  = 1'b0;
      end
   end

   // State and datapath registers; busy tracks the registered state
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         freq_q  <= '0;
         step_q  <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         dur_q   <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         step_q  <= step_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   assign freq_o = freq_q;
   assign gate_o = (state_q == StPlay) && (freq_q != 16'd0);
   assign step_o = step_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed self-checking bench for audio_note_sequencer (DEPTH=4, TICK_DIV=4, GAP_TICKS=1).
module tb_audio_note_sequencer;

   localparam int unsigned DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        cfg_we_i;
   logic [1:0]  cfg_addr_i;
   logic [31:0] cfg_data_i;
   logic [2:0]  len_i;
   logic        loop_i;
   logic        start_i;
   logic        stop_i;
   logic [15:0] freq_o;
   logic        gate_o;
   logic [1:0]  step_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   audio_note_sequencer #(
      .DEPTH     (DEPTH),
      .TICK_DIV  (4),
      .GAP_TICKS (1)
   ) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_addr_i (cfg_addr_i),
      .cfg_data_i (cfg_data_i),
      .len_i      (len_i),
      .loop_i     (loop_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .freq_o     (freq_o),
      .gate_o     (gate_o),
      .step_o     (step_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      cfg_we_i   = 1'b1;
      cfg_addr_i = addr;
      cfg_data_i = data;
      tick();
      cfg_we_i   = 1'b0;
   endtask

   // Returns with the DUT in its LOAD cycle for step 0
   task automatic start_seq(input logic [2:0] len, input logic lp);
      start_i = 1'b1;
      len_i   = len;
      loop_i  = lp;
      tick();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      #2;
      checks++;
      if ({freq_o, gate_o, step_o, busy_o, done_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got freq=%h gate=%b step=%0d busy=%b done=%b, want all 0",
                  freq_o, gate_o, step_o, busy_o, done_o);
      end
      tick();
      rstn_i = 1'b1;
      tick();
      checks++;
      if (busy_o !== 1'b0 || gate_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b gate=%b, want 0 0", busy_o, gate_o);
      end
   endtask

   task automatic test_single_play();
      logic        eg, ed, eb;
      logic [15:0] ef;
      wr(2'd0, {16'h1234, 16'd3});
      wr(2'd1, {16'h0800, 16'd1});
      start_seq(3'd2, 1'b0);
      checks++;
      if (busy_o !== 1'b1 || step_o !== 2'd0 || gate_o !== 1'b0) begin
         errors++;
         $display("FAIL single_load: got busy=%b step=%0d gate=%b, want 1 0 0",
                  busy_o, step_o, gate_o);
      end
      // LOAD at k=0; step0 play 1..12, gap 13..16; LOAD 17; step1 play 18..21, gap 22..25
      for (int k = 1; k <= 27; k++) begin
         tick();
         eg = (k >= 1 && k <= 12) || (k >= 18 && k <= 21);
         ef = (k <= 17) ? 16'h1234 : (k <= 25) ? 16'h0800 : 16'h0000;
         ed = (k == 26);
         eb = (k < 26);
         checks++;
         if (gate_o !== eg || freq_o !== ef || done_o !== ed || busy_o !== eb) begin
            errors++;
            $display("FAIL single_cycle%0d: got gate=%b freq=%h done=%b busy=%b, want %b %h %b %b",
                     k, gate_o, freq_o, done_o, busy_o, eg, ef, ed, eb);
         end
         if (k < 26) begin
            checks++;
            if (step_o !== ((k >= 17) ? 2'd1 : 2'd0)) begin
               errors++;
               $display("FAIL single_step%0d: got %0d want %0d", k, step_o, (k >= 17) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_rest_zero_dur();
      logic eg;
      wr(2'd0, {16'h0000, 16'd2});
      wr(2'd1, {16'h0100, 16'd0});
      start_seq(3'd2, 1'b0);
      // step0 rest: play 1..8, gap 9..12; LOAD 13; step1 play 14..17, gap 18..21; done 22
      for (int k = 1; k <= 22; k++) begin
         tick();
         eg = (k >= 14 && k <= 17);
         checks++;
         if (gate_o !== eg || done_o !== (k == 22)) begin
            errors++;
            $display("FAIL rest_cycle%0d: got gate=%b done=%b, want %b %b",
                     k, gate_o, done_o, eg, (k == 22));
         end
         if (k < 22) begin
            checks++;
            if (step_o !== ((k >= 13) ? 2'd1 : 2'd0)) begin
               errors++;
               $display("FAIL rest_step%0d: got %0d want %0d", k, step_o, (k >= 13) ? 1 : 0);
            end
         end
      end
      checks++;
      if (freq_o !== 16'h0000 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rest_end: got freq=%h busy=%b, want 0000 0", freq_o, busy_o);
      end
   endtask

   task automatic test_loop_stop();
      logic [1:0] es;
      wr(2'd0, {16'h1234, 16'd1});
      wr(2'd1, {16'h0800, 16'd1});
      start_seq(3'd2, 1'b1);
      // 9-cycle steps: LOAD at 0,9,18,27,36 alternating step 0/1
      for (int k = 1; k <= 40; k++) begin
         tick();
         es = 2'((k / 9) % 2);
         checks++;
         if (step_o !== es || done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL loop_cycle%0d: got step=%0d done=%b busy=%b, want %0d 0 1",
                     k, step_o, done_o, busy_o, es);
         end
      end
      checks++;
      if (gate_o !== 1'b1) begin
         errors++;
         $display("FAIL loop_in_play: got gate=%b want 1", gate_o);
      end
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || gate_o !== 1'b0 || freq_o !== 16'h0000 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL stop_next: got busy=%b gate=%b freq=%h done=%b, want 0 0 0000 0",
                  busy_o, gate_o, freq_o, done_o);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_stays_idle%0d: got busy=%b done=%b, want 0 0", k, busy_o, done_o);
         end
      end
   endtask

   task automatic test_clamp_ignore();
      for (int i = 0; i < DEPTH; i++) begin
         wr(2'(i), {16'h1000 + 16'(i), 16'd1});
      end
      start_seq(3'(DEPTH + 1), 1'b0);
      // DEPTH steps of 9 cycles each; a start at k=2 must not restart
      for (int k = 1; k <= 36; k++) begin
         tick();
         if (k == 2) begin
            start_i = 1'b1;
            len_i   = 3'd1;
         end else begin
            start_i = 1'b0;
         end
         checks++;
         if (done_o !== (k == 36)) begin
            errors++;
            $display("FAIL clamp_done%0d: got %b want %b", k, done_o, (k == 36));
         end
         if (k < 36) begin
            checks++;
            if (step_o !== 2'(k / 9)) begin
               errors++;
               $display("FAIL clamp_step%0d: got %0d want %0d", k, step_o, k / 9);
            end
         end
      end
      start_i = 1'b1;
      len_i   = 3'd0;
      tick();
      start_i = 1'b0;
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL start_len0: got busy=%b want 0", busy_o);
      end
      start_i = 1'b1;
      stop_i  = 1'b1;
      len_i   = 3'd2;
      tick();
      start_i = 1'b0;
      stop_i  = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || gate_o !== 1'b0) begin
         errors++;
         $display("FAIL start_with_stop: got busy=%b gate=%b want 0 0", busy_o, gate_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL start_with_stop_later: got busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_live_write();
      wr(2'd0, {16'h1234, 16'd1});
      wr(2'd1, {16'h5555, 16'd1});
      start_seq(3'd2, 1'b0);
      for (int k = 1; k <= 18; k++) begin
         tick();
         cfg_we_i = 1'b0;
         if (k == 2) begin
            cfg_we_i   = 1'b1;
            cfg_addr_i = 2'd1;
            cfg_data_i = {16'h0ABC, 16'd1};
         end
         if (k >= 10 && k <= 13) begin
            checks++;
            if (freq_o !== 16'h0ABC || gate_o !== 1'b1 || step_o !== 2'd1) begin
               errors++;
               $display("FAIL live_write%0d: got freq=%h gate=%b step=%0d, want 0abc 1 1",
                        k, freq_o, gate_o, step_o);
            end
         end
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL live_done: got %b want 1", done_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_gap();
      wr(2'd0, {16'h1234, 16'd1});
      wr(2'd1, {16'h0800, 16'd1});
      start_seq(3'd2, 1'b0);
      for (int k = 1; k <= 6; k++) tick();
      checks++;
      if (busy_o !== 1'b1 || gate_o !== 1'b0 || freq_o !== 16'h1234) begin
         errors++;
         $display("FAIL in_gap: got busy=%b gate=%b freq=%h, want 1 0 1234",
                  busy_o, gate_o, freq_o);
      end
      #2 rstn_i = 1'b0;
      #1;
      checks++;
      if ({freq_o, gate_o, step_o, busy_o, done_o} !== 21'd0) begin
         errors++;
         $display("FAIL async_reset: got freq=%h gate=%b step=%0d busy=%b done=%b, want all 0",
                  freq_o, gate_o, step_o, busy_o, done_o);
      end
      tick();
      tick();
      rstn_i = 1'b1;
      tick();
      start_seq(3'd2, 1'b0);
      checks++;
      if (busy_o !== 1'b1 || step_o !== 2'd0) begin
         errors++;
         $display("FAIL restart_load: got busy=%b step=%0d, want 1 0", busy_o, step_o);
      end
      tick();
      checks++;
      if (freq_o !== 16'h1234 || gate_o !== 1'b1) begin
         errors++;
         $display("FAIL restart_play: got freq=%h gate=%b, want 1234 1", freq_o, gate_o);
      end
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
   endtask

   initial begin
      rstn_i     = 1'b0;
      cfg_we_i   = 1'b0;
      cfg_addr_i = '0;
      cfg_data_i = '0;
      len_i      = '0;
      loop_i     = 1'b0;
      start_i    = 1'b0;
      stop_i     = 1'b0;
      test_reset();
      test_single_play();
      tick();
      test_rest_zero_dur();
      tick();
      test_loop_stop();
      test_clamp_ignore();
      test_live_write();
      test_reset_mid_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
